sram_bus_arbiter: RTL and testbench
===================================

Name: sram_bus_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch master and the load/store master of the 5-stage pipeline.
- Masters and slave all use the req/addr_ok/data_ok handshake.
- Exactly one transaction is outstanding at a time. Data has priority, with a bounded-starvation guarantee for fetch.
- Sits between the core's inst/data request logic and the unified memory port.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, maximum consecutive data grants while an inst request waits; the next grant goes to inst.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- inst_req  in  1  fetch request; held with its fields until inst_addr_ok.
- inst_addr  in  ADDR_W  fetch address; reads are always word size.
- inst_addr_ok  out  1  fetch address accepted.
- inst_data_ok  out  1  fetch data valid.
- inst_rdata  out  DATA_W  fetch data.
- data_req  in  1  load/store request; held with its fields until data_addr_ok.
- data_wr  in  1  1 = store.
- data_size  in  2  0 = byte, 1 = half, 2 = word.
- data_wstrb  in  4  store byte enables.
- data_addr  in  ADDR_W  load/store address.
- data_wdata  in  DATA_W  store data.
- data_addr_ok  out  1  load/store address accepted.
- data_data_ok  out  1  load data valid / store complete.
- data_rdata  out  DATA_W  load data.
- bus_req  out  1  slave request.
- bus_wr  out  1  slave write.
- bus_size  out  2  slave size.
- bus_wstrb  out  4  slave byte enables.
- bus_addr  out  ADDR_W  slave address.
- bus_wdata  out  DATA_W  slave write data.
- bus_addr_ok  in  1  slave accepted the address.
- bus_data_ok  in  1  slave data/response valid.
- bus_rdata  in  DATA_W  slave read data.

Behaviour:
- FSM states: IDLE, ADDR, DATA. Grant register owner (0 = inst, 1 = data). Starvation counter streak, 3 bits minimum.
- Reset (async, resetn = 0):
  - state = IDLE, owner = 0, streak = 0.
  - All bus_* outputs and latched fields = 0.
  - All *_addr_ok / *_data_ok = 0.
  - Any in-flight slave transaction is abandoned; late bus_data_ok after reset is ignored because state is IDLE.
- IDLE:
  - If data_req and inst_req are both 1: grant data unless streak == STARVE_LIMIT, then grant inst.
  - If only one request: grant it.
  - On a grant: latch that master's fields into bus_* registers (inst gets bus_wr = 0, bus_size = 2, bus_wstrb = 0, bus_wdata = 0), set owner, go to ADDR.
  - No request: stay in IDLE.
- Streak update, at the grant:
  - Data granted while inst_req = 1: streak + 1, saturating at STARVE_LIMIT.
  - Inst granted: streak = 0.
  - Data granted while inst_req = 0: streak unchanged.
- ADDR:
  - bus_req = 1, driven from the latched registers.
  - On bus_addr_ok: pulse the owner's *_addr_ok (combinational, same cycle) and go to DATA.
  - If bus_addr_ok and bus_data_ok are 1 in the same cycle: pulse both the owner's addr_ok and data_ok and go to IDLE.
- DATA:
  - bus_req = 0.
  - On bus_data_ok: pulse the owner's *_data_ok (combinational, same cycle) and go to IDLE.
  - The owner's *_rdata = bus_rdata; the non-owner's rdata = 0.
- Handshake outputs:
  - *_addr_ok and *_data_ok are never asserted for the non-owner.
  - They are never asserted in IDLE.
- Timing:
  - Minimum transaction time: 3 cycles (IDLE grant, ADDR, DATA), or 2 cycles with the simultaneous addr/data ack.
  - There is one IDLE bubble between back-to-back transactions.
- Master rule: a master must hold req and fields stable until addr_ok. The arbiter samples its fields only at grant, so later changes have no effect on the in-flight transaction.
- Deassertion: a req deasserted before grant is simply not served. A req deasserted after grant does not cancel the transaction.
- Stray acks: bus_data_ok in ADDR without bus_addr_ok, and bus_addr_ok in DATA or IDLE, are ignored.

Test Plan:
1. Lone fetch:
   - Stimulus: inst_req = 1, inst_addr = 0xBFC0_0000; slave gives addr_ok 1 cycle after bus_req and data_ok 2 cycles later with rdata = 0x2408_0001.
   - Required: bus_wr = 0, bus_size = 2; inst_addr_ok is a single-cycle pulse; inst_data_ok is a single-cycle pulse with inst_rdata = 0x2408_0001; data_* handshakes stay 0.
2. Simultaneous requests:
   - Stimulus: inst_req = 1 and a data store (addr 0x0000_1004, wdata 0xDEAD_BEEF, wstrb 0xF, size 2) requested in the same cycle.
   - Required: data is granted first, bus_wdata = 0xDEAD_BEEF; inst is served in the next transaction.
3. Starvation limit:
   - Stimulus: inst_req held high, data_req held high, STARVE_LIMIT = 4.
   - Required: grant sequence D, D, D, D, I, D…; streak resets to 0 after the inst grant.
4. Zero-latency slave:
   - Stimulus: slave asserts bus_addr_ok and bus_data_ok in the same cycle for a byte load at 0x0000_0003.
   - Required: data_addr_ok and data_data_ok pulse together; FSM returns to IDLE; next grant possible 1 cycle later.
5. Reset mid-transaction:
   - Stimulus: resetn = 0 while in DATA; release; slave then asserts bus_data_ok.
   - Required: all outputs 0 immediately on reset; the late data_ok produces no master data_ok.
6. Stray acks and unstable request fields:
   - Stimulus: bus_data_ok pulsed in IDLE and in ADDR; data_addr changed after grant but before addr_ok.
   - Required: no master handshake pulses from the stray acks; bus_addr keeps the value latched at grant.

Source files
------------

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like req/addr_ok/data_ok port between the fetch and load/store masters.
// One transaction in flight; data wins ties until fetch has waited STARVE_LIMIT data grants.
module sram_bus_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [3:0]        bus_wstrb,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    // state | meaning
    // IDLE  | no transaction; arbitrate and latch the winner's fields
    // ADDR  | bus_req high, waiting for bus_addr_ok
    // DATA  | address accepted, waiting for bus_data_ok
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    localparam int SW_RAW = $clog2(STARVE_LIMIT + 1);
    localparam int SW     = (SW_RAW > 3) ? SW_RAW : 3;
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic              bus_wr_q, bus_wr_d;
    logic [1:0]        bus_size_q, bus_size_d;
    logic [3:0]        bus_wstrb_q, bus_wstrb_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic              addr_ok_c, data_ok_c;
    logic              grant_data, grant_inst, rd_valid;

    assign grant_data = data_req && !(inst_req && (streak_q == LIMIT));
    assign grant_inst = inst_req && !grant_data;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            streak_q    <= '0;
            bus_wr_q    <= 1'b0;
            bus_size_q  <= 2'd0;
            bus_wstrb_q <= 4'd0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            streak_q    <= streak_d;
            bus_wr_q    <= bus_wr_d;
            bus_size_q  <= bus_size_d;
            bus_wstrb_q <= bus_wstrb_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        streak_d    = streak_q;
        bus_wr_d    = bus_wr_q;
        bus_size_d  = bus_size_q;
        bus_wstrb_d = bus_wstrb_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        addr_ok_c   = 1'b0;
        data_ok_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_data) begin
                    owner_d     = 1'b1;
                    bus_wr_d    = data_wr;
                    bus_size_d  = data_size;
                    bus_wstrb_d = data_wstrb;
                    bus_addr_d  = data_addr;
                    bus_wdata_d = data_wdata;
                    // Only count data grants that actually made fetch wait.
                    if (inst_req)
                        streak_d = (streak_q == LIMIT) ? LIMIT : streak_q + SW'(1);
                    state_d = ADDR;
                end else if (grant_inst) begin
                    owner_d     = 1'b0;
                    bus_wr_d    = 1'b0;
                    bus_size_d  = 2'd2;
                    bus_wstrb_d = 4'd0;
                    bus_addr_d  = inst_addr;
                    bus_wdata_d = '0;
                    streak_d    = '0;
                    state_d     = ADDR;
                end
            end
            ADDR: begin
                if (bus_addr_ok) begin
                    addr_ok_c = 1'b1;
                    if (bus_data_ok) begin
                        data_ok_c = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (bus_data_ok) begin
                    data_ok_c = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rd_valid     = (state_q != IDLE);
    assign inst_addr_ok = addr_ok_c && !owner_q;
    assign data_addr_ok = addr_ok_c && owner_q;
    assign inst_data_ok = data_ok_c && !owner_q;
    assign data_data_ok = data_ok_c && owner_q;
    assign inst_rdata   = (rd_valid && !owner_q) ? bus_rdata : '0;
    assign data_rdata   = (rd_valid && owner_q) ? bus_rdata : '0;

    assign bus_req   = (state_q == ADDR);
    assign bus_wr    = bus_wr_q;
    assign bus_size  = bus_size_q;
    assign bus_wstrb = bus_wstrb_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: master/slave models, grant scoreboard, vector table, corner sequences.
module tb_sram_bus_arbiter;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic owner;
        req_t r;
    } exp_t;

    typedef struct {
        bit          use_i;
        logic [31:0] iaddr;
        bit          use_d;
        req_t        d;
        int          alat;
        int          dlat;
        logic        first_owner;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
    logic [1:0]  bus_size;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    req_t inst_pend[$];
    req_t data_pend[$];
    exp_t exp_q[$];
    exp_t dexp_q[$];
    int   aok_cyc[$];
    int   dok_cyc[$];
    bit   inst_acc = 0, data_acc = 0;
    bit   inject_dok = 0, inject_aok = 0;
    int   alat = 0, dlat = 0;
    int   s_phase = 0, s_cnt = 0;

    sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] slave_data(logic [31:0] a);
        return (a == 32'hBFC0_0000) ? 32'h2408_0001 : (a ^ 32'hA5A5_A5A5);
    endfunction

    function automatic req_t mk_inst(logic [31:0] a);
        req_t r;
        r.wr = 1'b0; r.size = 2'd2; r.wstrb = 4'd0; r.addr = a; r.wdata = 32'd0;
        return r;
    endfunction

    function automatic req_t mk_data(logic wr, logic [1:0] sz, logic [3:0] st,
                                     logic [31:0] a, logic [31:0] wd);
        req_t r;
        r.wr = wr; r.size = sz; r.wstrb = st; r.addr = a; r.wdata = wd;
        return r;
    endfunction

    task automatic check(string name, logic [63:0] got, logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic expect_grant(logic owner, req_t r);
        exp_t e;
        e.owner = owner;
        e.r     = r;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(string name, int budget);
        int n = 0;
        while ((exp_q.size() + dexp_q.size() + inst_pend.size() + data_pend.size()) != 0
               && n < budget) begin
            @(posedge clk); #3;
            n++;
        end
        check({"done_", name}, 64'(exp_q.size() + dexp_q.size() + inst_pend.size() + data_pend.size()), 0);
        exp_q.delete(); dexp_q.delete(); inst_pend.delete(); data_pend.delete();
    endtask

    task automatic wait_bus_req(int budget);
        int n = 0;
        while (!bus_req && n < budget) begin
            @(posedge clk); #3;
            n++;
        end
        check("bus_req_seen", {63'd0, bus_req}, 1);
    endtask

    task automatic wait_addr_accepted(int budget);
        int n = 0;
        while (dexp_q.size() == 0 && n < budget) begin
            @(posedge clk); #3;
            n++;
        end
        check("addr_accepted", 64'(dexp_q.size()), 1);
    endtask

    // Master and slave models: drive at posedge+1
    initial begin
        forever begin
            @(posedge clk); #1;
            if (inst_acc && inst_pend.size() != 0) void'(inst_pend.pop_front());
            if (data_acc && data_pend.size() != 0) void'(data_pend.pop_front());
            inst_acc = 0;
            data_acc = 0;
            inst_req   = (inst_pend.size() != 0);
            inst_addr  = inst_req ? inst_pend[0].addr : 32'd0;
            data_req   = (data_pend.size() != 0);
            data_wr    = data_req ? data_pend[0].wr : 1'b0;
            data_size  = data_req ? data_pend[0].size : 2'd0;
            data_wstrb = data_req ? data_pend[0].wstrb : 4'd0;
            data_addr  = data_req ? data_pend[0].addr : 32'd0;
            data_wdata = data_req ? data_pend[0].wdata : 32'd0;

            bus_addr_ok = 1'b0;
            bus_data_ok = 1'b0;
            bus_rdata   = 32'd0;
            if (!resetn) begin
                s_phase = 0;
                s_cnt   = 0;
            end else if (s_phase == 0 && bus_req) begin
                if (s_cnt == alat) begin
                    bus_addr_ok = 1'b1;
                    s_cnt = 0;
                    if (dlat == 0) begin
                        bus_data_ok = 1'b1;
                        bus_rdata   = slave_data(bus_addr);
                    end else begin
                        s_phase = 1;
                    end
                end else begin
                    s_cnt++;
                end
            end else if (s_phase == 1) begin
                s_cnt++;
                if (s_cnt == dlat) begin
                    bus_data_ok = 1'b1;
                    bus_rdata   = slave_data(bus_addr);
                    s_phase = 0;
                    s_cnt   = 0;
                end
            end
            if (inject_dok) bus_data_ok = 1'b1;
            if (inject_aok) bus_addr_ok = 1'b1;
        end
    end

    // Scoreboard monitor: sample at posedge+2
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #2;
            cyc++;
            if (inst_addr_ok || data_addr_ok) begin
                aok_cyc.push_back(cyc);
                if (inst_addr_ok) inst_acc = 1;
                if (data_addr_ok) data_acc = 1;
                if (exp_q.size() == 0) begin
                    check("unexpected_addr_ok", {62'd0, inst_addr_ok, data_addr_ok}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("grant_owner", {62'd0, inst_addr_ok, data_addr_ok}, e.owner ? 64'd1 : 64'd2);
                    check("bus_addr", 64'(bus_addr), 64'(e.r.addr));
                    check("bus_wr", 64'(bus_wr), 64'(e.r.wr));
                    check("bus_size", 64'(bus_size), 64'(e.r.size));
                    check("bus_wstrb", 64'(bus_wstrb), 64'(e.r.wstrb));
                    check("bus_wdata", 64'(bus_wdata), 64'(e.r.wdata));
                    dexp_q.push_back(e);
                end
            end
            if (inst_data_ok || data_data_ok) begin
                dok_cyc.push_back(cyc);
                if (dexp_q.size() == 0) begin
                    check("unexpected_data_ok", {62'd0, inst_data_ok, data_data_ok}, 0);
                end else begin
                    e = dexp_q.pop_front();
                    check("done_owner", {62'd0, inst_data_ok, data_data_ok}, e.owner ? 64'd1 : 64'd2);
                    check("owner_rdata", 64'(e.owner ? data_rdata : inst_rdata), 64'(slave_data(e.r.addr)));
                    check("other_rdata", 64'(e.owner ? inst_rdata : data_rdata), 0);
                end
            end
        end
    end

    initial begin
        vec_t vecs[6];
        int   n0;
        int   m0;

        inst_req = 0; inst_addr = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
        resetn = 1'b1;
        #2 resetn = 1'b0;

        vecs[0] = '{1, 32'hBFC0_0000, 0, mk_data(0, 2'd0, 4'h0, 32'h0, 32'h0), 1, 2, 1'b0};
        vecs[1] = '{1, 32'hBFC0_0004, 1, mk_data(1, 2'd2, 4'hF, 32'h0000_1004, 32'hDEAD_BEEF), 0, 1, 1'b1};
        vecs[2] = '{0, 32'h0, 1, mk_data(0, 2'd2, 4'h0, 32'h0000_2000, 32'h0), 2, 0, 1'b1};
        vecs[3] = '{0, 32'h0, 1, mk_data(0, 2'd0, 4'h0, 32'h0000_0003, 32'h0), 0, 0, 1'b1};
        vecs[4] = '{0, 32'h0, 1, mk_data(1, 2'd1, 4'hC, 32'h0000_0102, 32'h1234_5678), 0, 3, 1'b1};
        vecs[5] = '{1, 32'h8000_0010, 1, mk_data(0, 2'd2, 4'h0, 32'h0000_0040, 32'h0), 3, 2, 1'b1};

        repeat (2) @(posedge clk);
        #3;
        check("rst_bus_ctl", {56'd0, bus_req, bus_wr, bus_size, bus_wstrb}, 0);
        check("rst_bus_addr", 64'(bus_addr), 0);
        check("rst_handshake", {60'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
        @(posedge clk); #3;
        resetn = 1'b1;

        for (int i = 0; i < 6; i++) begin
            alat = vecs[i].alat;
            dlat = vecs[i].dlat;
            if (vecs[i].use_i) inst_pend.push_back(mk_inst(vecs[i].iaddr));
            if (vecs[i].use_d) data_pend.push_back(vecs[i].d);
            if (vecs[i].use_i && vecs[i].use_d) begin
                if (vecs[i].first_owner) begin
                    expect_grant(1'b1, vecs[i].d);
                    expect_grant(1'b0, mk_inst(vecs[i].iaddr));
                end else begin
                    expect_grant(1'b0, mk_inst(vecs[i].iaddr));
                    expect_grant(1'b1, vecs[i].d);
                end
            end else if (vecs[i].use_i) begin
                expect_grant(1'b0, mk_inst(vecs[i].iaddr));
            end else begin
                expect_grant(1'b1, vecs[i].d);
            end
            wait_done($sformatf("vec%0d", i), 60);
        end

        // Zero-latency slave followed immediately by another load
        alat = 0; dlat = 0;
        n0 = aok_cyc.size();
        m0 = dok_cyc.size();
        data_pend.push_back(mk_data(0, 2'd0, 4'h0, 32'h0000_0003, 32'h0));
        data_pend.push_back(mk_data(0, 2'd2, 4'h0, 32'h0000_0008, 32'h0));
        expect_grant(1'b1, data_pend[0]);
        expect_grant(1'b1, data_pend[1]);
        wait_done("zero_lat", 40);
        check("zl_count", 64'(aok_cyc.size() - n0), 2);
        if (aok_cyc.size() >= n0 + 2 && dok_cyc.size() >= m0 + 1) begin
            check("zl_same_cycle", 64'(dok_cyc[m0]), 64'(aok_cyc[n0]));
            check("zl_b2b_gap", 64'(aok_cyc[n0 + 1] - aok_cyc[n0]), 2);
        end

        // Starvation: D D D D I D D D D I D with both masters continuously requesting
        alat = 0; dlat = 1;
        for (int k = 0; k < 9; k++)
            data_pend.push_back(mk_data(0, 2'd2, 4'h0, 32'h0000_0100 + 32'(4 * k), 32'h0));
        inst_pend.push_back(mk_inst(32'hBFC0_0100));
        inst_pend.push_back(mk_inst(32'hBFC0_0104));
        for (int k = 0; k < 4; k++) expect_grant(1'b1, data_pend[k]);
        expect_grant(1'b0, inst_pend[0]);
        for (int k = 4; k < 8; k++) expect_grant(1'b1, data_pend[k]);
        expect_grant(1'b0, inst_pend[1]);
        expect_grant(1'b1, data_pend[8]);
        wait_done("starve", 200);

        // Stray acks in IDLE
        @(posedge clk); #3;
        inject_dok = 1; inject_aok = 1;
        @(posedge clk); #3;
        check("stray_idle_hs", {60'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
        inject_dok = 0; inject_aok = 0;
        @(posedge clk); #3;
        check("stray_idle_req", {63'd0, bus_req}, 0);

        // Stray data_ok in ADDR and request fields changed after grant
        alat = 4; dlat = 3;
        data_pend.push_back(mk_data(0, 2'd2, 4'h0, 32'h0000_5000, 32'h0));
        expect_grant(1'b1, data_pend[0]);
        wait_bus_req(10);
        data_pend[0].addr = 32'h0000_6000;
        inject_dok = 1;
        @(posedge clk); #3;
        check("stray_addr_hs", {60'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
        check("stray_addr_req", {63'd0, bus_req}, 1);
        check("latched_addr", 64'(bus_addr), 64'h0000_5000);
        inject_dok = 0;
        wait_addr_accepted(20);
        inject_aok = 1;
        @(posedge clk); #3;
        check("stray_data_aok", {62'd0, inst_addr_ok, data_addr_ok}, 0);
        inject_aok = 0;
        wait_done("stray", 40);

        // Reset while in DATA, then a late data_ok
        alat = 0; dlat = 8;
        inst_pend.push_back(mk_inst(32'hBFC0_0200));
        expect_grant(1'b0, inst_pend[0]);
        wait_addr_accepted(20);
        @(posedge clk); #3;
        resetn = 1'b0;
        #1;
        check("mid_rst_bus_ctl", {56'd0, bus_req, bus_wr, bus_size, bus_wstrb}, 0);
        check("mid_rst_bus_addr", 64'(bus_addr), 0);
        check("mid_rst_bus_wdata", 64'(bus_wdata), 0);
        check("mid_rst_hs", {60'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
        check("mid_rst_rdata", {inst_rdata, data_rdata}, 0);
        exp_q.delete(); dexp_q.delete(); inst_pend.delete(); data_pend.delete();
        repeat (2) @(posedge clk);
        #3;
        resetn = 1'b1;
        @(posedge clk); #3;
        inject_dok = 1;
        @(posedge clk); #3;
        check("late_dok_hs", {62'd0, inst_data_ok, data_data_ok}, 0);
        check("late_dok_req", {63'd0, bus_req}, 0);
        inject_dok = 0;

        alat = 1; dlat = 2;
        inst_pend.push_back(mk_inst(32'hBFC0_0000));
        expect_grant(1'b0, inst_pend[0]);
        wait_done("post_reset", 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
